// File: rtl/apb_manager_param.sv
// APB3 manager: turns single request/ready handshakes into APB transfers to NUM_SLV address-decoded slaves.
// Optional ACCESS-phase watchdog is compiled in when APB_TIMEOUT_EN is defined.
module apb_manager_param #(
   parameter int unsigned          NUM_SLV       = 4,
   parameter int unsigned          ADDR_W        = 32,
   parameter int unsigned          DATA_W        = 32,
   parameter logic [ADDR_W-1:0]    BASE_ADDR     = 32'h1000_0000,
   parameter int unsigned          SLV_SPAN_BITS = 12,
   parameter int unsigned          TIMEOUT_CYC   = 16
) (
   input  logic                        PCLK,
   input  logic                        PRESET,
   input  logic                        transfer,
   input  logic                        write,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [DATA_W-1:0]           wdata,
   output logic [DATA_W-1:0]           rdata,
   output logic                        ready,
   output logic                        err,
   output logic                        busy,
   output logic [ADDR_W-1:0]           PADDR,
   output logic                        PWRITE,
   output logic                        PENABLE,
   output logic [DATA_W-1:0]           PWDATA,
   output logic [NUM_SLV-1:0]          PSEL,
   input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
   input  logic [NUM_SLV-1:0]          PREADY,
   input  logic [NUM_SLV-1:0]          PSLVERR
);

   localparam int unsigned        IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int unsigned        TAG_LO  = SLV_SPAN_BITS + IDX_W;
   localparam logic [IDX_W:0]     SLV_CNT = (IDX_W+1)'(NUM_SLV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DECERR
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx_q;

   logic [IDX_W-1:0]  req_idx;
   logic              req_hit;

   logic              sel_ready;
   logic              sel_err;
   logic [DATA_W-1:0] sel_rdata;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned    WD_W    = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0]           wd_cnt;
`endif

   // Window index sits just above the per-slave span; everything above it must match the base.
   always_comb begin
      // NOTE: both decode results are assigned on every pass, so no latch can be inferred.
      req_idx = addr[SLV_SPAN_BITS +: IDX_W];
      req_hit = (addr[ADDR_W-1:TAG_LO] == BASE_ADDR[ADDR_W-1:TAG_LO]) &&
                ({1'b0, req_idx} < SLV_CNT);
   end

   // Only the captured slave's response lines are ever looked at.
   assign sel_ready = PREADY[idx_q];
   assign sel_err   = PSLVERR[idx_q];
   assign sel_rdata = PRDATA[idx_q*DATA_W +: DATA_W];

   function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= S_IDLE;
         idx_q   <= '0;
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         PENABLE <= 1'b0;
         PSEL    <= '0;
         rdata   <= '0;
         ready   <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wd_cnt  <= '0;
`endif
      end else begin
         // NOTE: non-blocking updates throughout, so every branch sees the pre-edge state.
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (transfer) begin
                  busy <= 1'b1;
                  if (req_hit) begin
                     state  <= S_SETUP;
                     idx_q  <= req_idx;
                     PSEL   <= onehot(req_idx);
                     PADDR  <= addr;
                     PWRITE <= write;
                     PWDATA <= wdata;
                  end else begin
                     state <= S_DECERR;
                  end
               end
            end

            S_SETUP: begin
               state   <= S_ACCESS;
               PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wd_cnt  <= '0;
`endif
            end

            S_ACCESS: begin
               if (sel_ready) begin
                  state   <= S_IDLE;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  busy    <= 1'b0;
                  ready   <= 1'b1;
                  err     <= sel_err;
                  if (!PWRITE) begin
                     rdata <= sel_rdata;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  state   <= S_IDLE;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  busy    <= 1'b0;
                  ready   <= 1'b1;
                  err     <= 1'b1;
                  rdata   <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end

            S_DECERR: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               ready <= 1'b1;
               err   <= 1'b1;
               rdata <= '0;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_manager_param.sv
// Self-checking bench for apb_manager_param: vector table, hand-written corner sequences and a random run
// scored against an address-arithmetic reference model. Honours APB_TIMEOUT_EN for the watchdog case.
module tb_apb_manager_param;

   localparam int          NUM_SLV     = 4;
   localparam int          ADDR_W      = 32;
   localparam int          DATA_W      = 32;
   localparam int          TIMEOUT_CYC = 16;
   localparam logic [31:0] BASE        = 32'h1000_0000;

   logic                      PCLK     = 1'b0;
   logic                      PRESET   = 1'b1;
   logic                      transfer = 1'b0;
   logic                      write    = 1'b0;
   logic [ADDR_W-1:0]         addr     = '0;
   logic [DATA_W-1:0]         wdata    = '0;
   logic [DATA_W-1:0]         rdata;
   logic                      ready;
   logic                      err;
   logic                      busy;
   logic [ADDR_W-1:0]         PADDR;
   logic                      PWRITE;
   logic                      PENABLE;
   logic [DATA_W-1:0]         PWDATA;
   logic [NUM_SLV-1:0]        PSEL;
   logic [NUM_SLV*DATA_W-1:0] PRDATA;
   logic [NUM_SLV-1:0]        PREADY;
   logic [NUM_SLV-1:0]        PSLVERR;

   apb_manager_param #(
      .NUM_SLV       (NUM_SLV),
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .BASE_ADDR     (BASE),
      .SLV_SPAN_BITS (12),
      .TIMEOUT_CYC   (TIMEOUT_CYC)
   ) dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .busy     (busy),
      .PADDR    (PADDR),
      .PWRITE   (PWRITE),
      .PENABLE  (PENABLE),
      .PWDATA   (PWDATA),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   // ---------------- memory slaves with configurable wait / error / hang ----------------
   int                 wait_cfg [NUM_SLV] = '{default: 0};
   logic [NUM_SLV-1:0] hang      = '0;
   logic [NUM_SLV-1:0] err_cfg   = '0;
   logic [NUM_SLV-1:0] rdy_noise = '0;
   logic [31:0]        mem [NUM_SLV][1024];
   int                 acc_cnt = 0;

   initial begin
      for (int s = 0; s < NUM_SLV; s++)
         for (int w = 0; w < 1024; w++)
            mem[s][w] = 32'h0;
   end

   always_comb begin
      PREADY = '0;
      PRDATA = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         PREADY[i] = PSEL[i] ? (PENABLE && !hang[i] && (acc_cnt >= wait_cfg[i])) : rdy_noise[i];
         PRDATA[i*DATA_W +: DATA_W] = mem[i][PADDR[11:2]];
      end
   end

   assign PSLVERR = err_cfg;

   always @(posedge PCLK) begin
      if (PENABLE && !(|(PSEL & PREADY))) acc_cnt <= acc_cnt + 1;
      else                                 acc_cnt <= 0;
      for (int i = 0; i < NUM_SLV; i++)
         if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) mem[i][PADDR[11:2]] <= PWDATA;
   end

   // ---------------- monitors (sampled on the falling edge) ----------------
   int cyc       = 0;
   int ready_cnt = 0;
   int pen_cnt   = 0;
   int xfer_cnt  = 0;
   int psel_bad  = 0;
   int sel_cnt [NUM_SLV] = '{default: 0};

   always @(posedge PCLK) cyc <= cyc + 1;

   always @(negedge PCLK) begin
      if (ready)                        ready_cnt++;
      if (PENABLE)                      pen_cnt++;
      if (PENABLE && |(PSEL & PREADY))  xfer_cnt++;
      if (!$onehot0(PSEL))              psel_bad++;
      for (int i = 0; i < NUM_SLV; i++)
         if (PSEL[i]) sel_cnt[i]++;
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model: flat word store over the APB window ----------------
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] ref_rdata = 32'h0;

   task automatic ref_decode(input logic [31:0] a, output bit hit, output int slv, output int unsigned key);
      longint off;
      off = longint'(a) - longint'(BASE);
      hit = (off >= 0) && (off < longint'(NUM_SLV) * 4096);
      slv = hit ? int'(off / 4096) : 0;
      key = hit ? int'(off / 4) : 0;
   endtask

   task automatic ref_step(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] exp_rd, output bit exp_e, output int exp_lat,
                           output logic [NUM_SLV-1:0] exp_sel);
      bit hit; int slv; int unsigned key;
      ref_decode(a, hit, slv, key);
      exp_sel = '0;
      if (!hit) begin
         ref_rdata = 32'h0;
         exp_e     = 1'b1;
         exp_lat   = 1;
      end else begin
         exp_sel[slv] = 1'b1;
         exp_e        = err_cfg[slv];
         exp_lat      = 2 + wait_cfg[slv];
         if (wr) ref_mem[key] = d;
         else    ref_rdata = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
      end
      exp_rd = ref_rdata;
   endtask

   // ---------------- request-side driver ----------------
   int t0 = 0;

   task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
      transfer = 1'b1;
      write    = wr;
      addr     = a;
      wdata    = d;
      t0       = cyc + 1;
      @(negedge PCLK);
      transfer = 1'b0;
   endtask

   task automatic wait_ready(output int lat, output logic [31:0] rd, output logic e);
      lat = -1;
      rd  = '0;
      e   = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (ready === 1'b1) begin
            lat = cyc - t0;
            rd  = rdata;
            e   = err;
            return;
         end
         @(negedge PCLK);
      end
      n_tests++;
      n_fail++;
      $display("FAIL ready timeout: no ready within 300 cycles, required one");
   endtask

   task automatic do_txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input bit exp_e, input int exp_lat,
                         input logic [NUM_SLV-1:0] exp_sel);
      int                 rc0, lat;
      int                 s0 [NUM_SLV];
      logic [31:0]        rd;
      logic               e;
      logic [NUM_SLV-1:0] seen;
      rc0 = ready_cnt;
      s0  = sel_cnt;
      issue(wr, a, d);
      wait_ready(lat, rd, e);
      @(negedge PCLK);
      for (int i = 0; i < NUM_SLV; i++) seen[i] = (sel_cnt[i] != s0[i]);
      check({tag, " rdata"},  rd,             exp_rd);
      check({tag, " err"},    e,              exp_e);
      check({tag, " lat"},    lat,            exp_lat);
      check({tag, " pulses"}, ready_cnt - rc0, 1);
      check({tag, " psel"},   seen,           exp_sel);
   endtask

   task automatic model_txn(input string tag, input bit wr, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] er; bit ee; int el; logic [NUM_SLV-1:0] es;
      ref_step(wr, a, d, er, ee, el, es);
      do_txn(tag, wr, a, d, er, ee, el, es);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          perr;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs [16];

   initial begin
      #1_000_000;
      $display("FAIL global time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [31:0]        er, ea, eb, rd;
      bit                 ee, eea, eeb;
      int                 el, ela, elb, lat, r0, x0, p0, s1;
      logic [NUM_SLV-1:0] es, onehot_t;
      logic               e;
      bit                 hit;
      int                 slv;
      int unsigned        key;
      logic [31:0]        a, d;
      bit                 wr;

      vecs[0]  = '{1'b1, 32'h1000_0000, 32'h1234_5678, 1'b0, 32'h0,          1'b0, 2};
      vecs[1]  = '{1'b1, 32'h1000_1000, 32'hDEAD_BEEF, 1'b0, 32'h0,          1'b0, 2};
      vecs[2]  = '{1'b1, 32'h1000_2000, 32'hCAFE_BABE, 1'b0, 32'h0,          1'b0, 2};
      vecs[3]  = '{1'b1, 32'h1000_3000, 32'h8765_4321, 1'b0, 32'h0,          1'b0, 2};
      vecs[4]  = '{1'b0, 32'h1000_0000, 32'h0,         1'b0, 32'h1234_5678,  1'b0, 2};
      vecs[5]  = '{1'b0, 32'h1000_1000, 32'h0,         1'b0, 32'hDEAD_BEEF,  1'b0, 2};
      vecs[6]  = '{1'b0, 32'h1000_2000, 32'h0,         1'b0, 32'hCAFE_BABE,  1'b0, 2};
      vecs[7]  = '{1'b0, 32'h1000_3000, 32'h0,         1'b0, 32'h8765_4321,  1'b0, 2};
      vecs[8]  = '{1'b0, 32'h1000_3000, 32'h0,         1'b1, 32'h8765_4321,  1'b1, 2};
      vecs[9]  = '{1'b0, 32'h2000_0000, 32'h0,         1'b0, 32'h0,          1'b1, 1};
      vecs[10] = '{1'b1, 32'h1000_0004, 32'hAAAA_5555, 1'b0, 32'h0,          1'b0, 2};
      vecs[11] = '{1'b0, 32'h1000_0004, 32'h0,         1'b0, 32'hAAAA_5555,  1'b0, 2};
      vecs[12] = '{1'b0, 32'h1000_4000, 32'h0,         1'b0, 32'h0,          1'b1, 1};
      vecs[13] = '{1'b1, 32'h1000_1FFC, 32'h0F0F_0F0F, 1'b0, 32'h0,          1'b0, 2};
      vecs[14] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         1'b0, 32'h0,          1'b1, 1};
      vecs[15] = '{1'b0, 32'h1000_1FFC, 32'h0,         1'b0, 32'h0F0F_0F0F,  1'b0, 2};

      // ---- power-on reset ----
      repeat (3) @(negedge PCLK);
      check("por outputs", {PADDR, PWDATA, rdata, PSEL, PENABLE, PWRITE, ready, err, busy}, 0);
      PRESET = 1'b0;
      @(negedge PCLK);

      // ---- reset in the middle of an ACCESS to slave 2 ----
      wait_cfg[2] = 10;
      issue(1'b1, 32'h1000_2010, 32'h5555_AAAA);
      repeat (3) @(negedge PCLK);
      check("pre-reset penable", PENABLE, 1'b1);
      check("pre-reset psel",    PSEL,    4'b0100);
      r0 = ready_cnt;
      #2 PRESET = 1'b1;
      #1 check("async reset outputs", {PADDR, PWDATA, rdata, PSEL, PENABLE, PWRITE, ready, err, busy}, 0);
      @(negedge PCLK);
      check("held reset outputs", {PADDR, PWDATA, rdata, PSEL, PENABLE, PWRITE, ready, err, busy}, 0);
      PRESET = 1'b0;
      repeat (2) @(negedge PCLK);
      check("no ready after abort", ready_cnt - r0, 0);
      wait_cfg[2] = 0;
      model_txn("post-reset write", 1'b1, 32'h1000_2010, 32'h0BAD_F00D);

      // ---- vector table ----
      for (int i = 0; i < 16; i++) begin
         ref_decode(vecs[i].addr, hit, slv, key);
         onehot_t = '0;
         if (hit) onehot_t[slv] = 1'b1;
         err_cfg = !hit ? '1 : (vecs[i].perr ? onehot_t : ~onehot_t);
         ref_step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, er, ee, el, es);
         do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, es);
      end
      err_cfg = '0;

      // ---- wait states on slave 1 ----
      wait_cfg[1] = 5;
      p0 = pen_cnt;
      model_txn("wait5 read", 1'b0, 32'h1000_1000, 32'h0);
      check("wait5 penable cycles", pen_cnt - p0, 6);
      wait_cfg[1] = 0;

      // ---- transfer pulsed while busy is dropped ----
      wait_cfg[0] = 3;
      ref_step(1'b0, 32'h1000_0000, 32'h0, er, ee, el, es);
      r0 = ready_cnt; x0 = xfer_cnt; s1 = sel_cnt[1];
      issue(1'b0, 32'h1000_0000, 32'h0);
      check("busy after accept", busy, 1'b1);
      transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'hFFFF_FFFF;
      @(negedge PCLK);
      transfer = 1'b0;
      wait_ready(lat, rd, e);
      @(negedge PCLK);
      check("busy-drop rdata",   rd,                er);
      check("busy-drop lat",     lat,               el);
      check("busy-drop apb xfers", xfer_cnt - x0,   1);
      check("busy-drop psel1",   sel_cnt[1] - s1,   0);
      check("busy-drop pulses",  ready_cnt - r0,    1);
      wait_cfg[0] = 0;
      model_txn("dropped write absent", 1'b0, 32'h1000_1000, 32'h0);

      // ---- back-to-back: next request presented in the ready cycle ----
      ref_step(1'b0, 32'h1000_2000, 32'h0, ea, eea, ela, es);
      ref_step(1'b0, 32'h1000_3000, 32'h0, eb, eeb, elb, es);
      r0 = ready_cnt; x0 = xfer_cnt;
      issue(1'b0, 32'h1000_2000, 32'h0);
      wait_ready(lat, rd, e);
      check("b2b A rdata", rd,  ea);
      check("b2b A lat",   lat, ela);
      issue(1'b0, 32'h1000_3000, 32'h0);
      wait_ready(lat, rd, e);
      @(negedge PCLK);
      check("b2b B rdata",  rd,              eb);
      check("b2b B err",    e,               eeb);
      check("b2b B lat",    lat,             elb);
      check("b2b pulses",   ready_cnt - r0,  2);
      check("b2b apb xfers", xfer_cnt - x0,  2);

      // ---- slave that never answers ----
      hang[3] = 1'b1;
      ref_step(1'b0, 32'h1000_3000, 32'h0, er, ee, el, es);
      r0 = ready_cnt; p0 = pen_cnt;
      issue(1'b0, 32'h1000_3000, 32'h0);
`ifdef APB_TIMEOUT_EN
      wait_ready(lat, rd, e);
      @(negedge PCLK);
      check("watchdog lat",     lat,            TIMEOUT_CYC + 1);
      check("watchdog rdata",   rd,             32'h0);
      check("watchdog err",     e,              1'b1);
      check("watchdog penable", pen_cnt - p0,   TIMEOUT_CYC);
      check("watchdog pulses",  ready_cnt - r0, 1);
      ref_rdata = 32'h0;
      hang[3] = 1'b0;
`else
      repeat (100) @(negedge PCLK);
      check("hang penable",  PENABLE,        1'b1);
      check("hang busy",     busy,           1'b1);
      check("hang no ready", ready_cnt - r0, 0);
      hang[3] = 1'b0;
      wait_ready(lat, rd, e);
      @(negedge PCLK);
      check("hang release rdata",   rd,            er);
      check("hang release err",     e,             ee);
      check("hang penable cycles",  pen_cnt - p0,  100);
`endif
      model_txn("after hang", 1'b0, 32'h1000_0000, 32'h0);

      // ---- randomized traffic against the reference model ----
      for (int n = 0; n < 80; n++) begin
         for (int i = 0; i < NUM_SLV; i++) wait_cfg[i] = $urandom_range(0, 3);
         err_cfg   = NUM_SLV'($urandom);
         rdy_noise = NUM_SLV'($urandom);
         wr = 1'($urandom);
         d  = $urandom;
         if ($urandom_range(0, 99) < 85) begin
            a = BASE + 32'($urandom_range(0, NUM_SLV - 1)) * 32'h1000 + 32'(4 * $urandom_range(0, 15));
         end else begin
            case ($urandom_range(0, 2))
               0:       a = $urandom | 32'h8000_0000;
               1:       a = BASE + 32'(NUM_SLV) * 32'h1000 + 32'(4 * $urandom_range(0, 15));
               default: a = BASE - 32'(4 + 4 * $urandom_range(0, 15));
            endcase
         end
         model_txn($sformatf("rnd%0d", n), wr, a, d);
      end
      rdy_noise = '0;
      err_cfg   = '0;

      check("psel one-hot throughout", psel_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_manager_param.md
Name: apb_manager_param

Overview:
Parametrised APB3 manager bridging the internal request interface (transfer/write/addr/wdata -> rdata/ready) to NUM_SLV APB slaves.
- Address-decoded PSEL per slave.
- PSLVERR propagation and decode-error completion for unmapped addresses.
- Optional ACCESS-phase watchdog.
- Successor to the fixed 4-slave manager; sits between the CPU-side bus and the peripheral APB slaves.

Parameters:
NUM_SLV, 4, number of APB slaves (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
BASE_ADDR, 32'h1000_0000, base of APB region
SLV_SPAN_BITS, 12, log2 of per-slave window (4 KB)
TIMEOUT_CYC, 16, watchdog limit in ACCESS cycles (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
transfer  in  1  request strobe, sampled only in IDLE
write  in  1  1=write, 0=read; captured with transfer
addr  in  ADDR_W  request address; captured with transfer
wdata  in  DATA_W  write data; captured with transfer
rdata  out  DATA_W  read data, valid while ready=1
ready  out  1  one-cycle completion pulse
err  out  1  error flag, valid while ready=1
busy  out  1  high whenever state != IDLE
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  APB write data
PSEL  out  NUM_SLV  one-hot slave select
PRDATA  in  NUM_SLV*DATA_W  slave read data; slave i at bits [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  slave ready
PSLVERR  in  NUM_SLV  slave error

Behaviour:
Clock and reset:
- Single clock PCLK. PRESET asynchronous, active-high.
- During or after reset: state=IDLE, all outputs 0 (PADDR, PWDATA, rdata, PSEL, PENABLE, PWRITE, ready, err, busy).
- Reset mid-transfer aborts immediately. No completion pulse is generated.

Decode (combinational on captured addr):
- Hit when addr[ADDR_W-1:SLV_SPAN_BITS+IDX_W] == BASE_ADDR[same bits], where IDX_W = max(1, clog2(NUM_SLV)).
- idx = addr[SLV_SPAN_BITS +: IDX_W].
- idx >= NUM_SLV counts as a miss.

FSM (all outputs registered):
- IDLE: on posedge with transfer=1, capture write/addr/wdata.
  - Hit -> SETUP.
  - Miss -> DECERR.
- SETUP: PSEL[idx]=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from captured values. Next posedge -> ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1.
  - On posedge with PREADY[idx]=1 -> IDLE.
  - Registered for the following cycle: ready=1, err=PSLVERR[idx], rdata=PRDATA slice idx (reads only; writes hold the previous rdata).
  - Wait states are unbounded unless APB_TIMEOUT_EN is defined.
- DECERR: no PSEL asserted. Next posedge -> IDLE with ready=1, err=1, rdata=0.

Timing and handshake:
- PREADY/PSLVERR of unselected slaves are ignored.
- Zero-wait latency: transfer sampled at edge T; SETUP in T..T+1; ACCESS in T+1..T+2; ready high T+2..T+3.
- A transfer arriving in the same cycle as ready is sampled (state is IDLE), which allows back-to-back requests with one idle-free gap.
- transfer while busy=1 is ignored and dropped; the requester must check busy.
- PSEL deasserts and PENABLE drops to 0 in the cycle ready is high.
- PADDR/PWDATA hold their last values when idle.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8-bit-min counter clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - Reaching TIMEOUT_CYC forces ACCESS->IDLE with ready=1, err=1, rdata=0.
  - PSEL/PENABLE drop on that same edge.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
1. Reset check: assert PRESET mid-ACCESS to slave 2 -> next sample all outputs 0, busy=0, no ready pulse; deassert, then a new write completes normally.
2. Write/read all slaves (NUM_SLV=4, zero-wait memory slaves): write 32'h12345678, DEADBEEF, CAFEBABE, 87654321 to 0x1000_0000/1000/2000/3000; read back.
   - Each read returns the matching data with err=0.
   - Exactly one PSEL bit is high per transfer.
   - ready arrives 2 cycles after transfer.
3. Wait states: slave 1 holds PREADY=0 for 5 ACCESS cycles -> PENABLE stays high for 6 cycles; ready pulses exactly once for 1 cycle.
4. Errors:
   - Slave 3 returns PSLVERR=1 with PREADY -> err=1 on the ready cycle.
   - Access to 0x2000_0000 -> no PSEL, ready+err one cycle after capture, rdata=0.
5. Request during busy: pulse transfer while busy=1 -> ignored, only the first transaction appears on APB. Back-to-back transfer on the ready cycle -> accepted.
6. Watchdog (APB_TIMEOUT_EN, TIMEOUT_CYC=16): slave never asserts PREADY -> ready=1, err=1 after 16 ACCESS cycles; next transfer proceeds. Without the macro, the bus stays in ACCESS for 100 cycles.
